// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: emits a loaded word MSB-first, one bit per clock,
// optionally repeated with idle gaps, as the data source for the sequence detectors.
module seq_pattern_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned REP_W  = 4,
    parameter int unsigned GAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    input  logic [LEN_W-1:0]  len,
    input  logic [REP_W-1:0]  reps,
    input  logic [GAP_W-1:0]  gap,
    input  logic              abort,
    output logic              x,
    output logic              x_valid,
    output logic              frame_start,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   pattern_q, pattern_d;
    logic [IDX_W-1:0]    first_idx_q, first_idx_d;
    logic [REP_W-1:0]    rep_left_q, rep_left_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic x_q, x_d;
    logic x_valid_q, x_valid_d;
    logic frame_start_q, frame_start_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Operand normalisation at capture time: clamp length, treat zero reps as one.
    logic [LEN_W-1:0] len_clamped_c;
    logic [IDX_W-1:0] first_idx_c;
    logic [REP_W-1:0] reps_eff_c;
    logic [IDX_W-1:0] idx_dec_c;

    always_comb begin
        len_clamped_c = (32'(len) > DATA_W) ? LEN_W'(DATA_W) : len;
        first_idx_c   = IDX_W'(len_clamped_c - LEN_W'(1));
        reps_eff_c    = (reps == '0) ? REP_W'(1) : reps;
        idx_dec_c     = bit_idx_q - IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pattern_q     <= '0;
            first_idx_q   <= '0;
            rep_left_q    <= '0;
            gap_q         <= '0;
            bit_idx_q     <= '0;
            gap_cnt_q     <= '0;
            x_q           <= 1'b0;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            first_idx_q   <= first_idx_d;
            rep_left_q    <= rep_left_d;
            gap_q         <= gap_d;
            bit_idx_q     <= bit_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            x_q           <= x_d;
            x_valid_q     <= x_valid_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next state and next registered outputs; outputs describe the cycle after the edge.
    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        first_idx_d   = first_idx_q;
        rep_left_d    = rep_left_q;
        gap_d         = gap_q;
        bit_idx_d     = bit_idx_q;
        gap_cnt_d     = gap_cnt_q;
        x_d           = 1'b0;
        x_valid_d     = 1'b0;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d       = ST_SHIFT;
                        pattern_d     = pattern;
                        first_idx_d   = first_idx_c;
                        rep_left_d    = reps_eff_c;
                        gap_d         = gap;
                        bit_idx_d     = first_idx_c;
                        x_d           = pattern[first_idx_c];
                        x_valid_d     = 1'b1;
                        frame_start_d = 1'b1;
                        busy_d        = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    bit_idx_d = '0;
                    gap_cnt_d = '0;
                end else if (bit_idx_q != '0) begin
                    bit_idx_d = idx_dec_c;
                    x_d       = pattern_q[idx_dec_c];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else if (rep_left_q > REP_W'(1)) begin
                    rep_left_d = rep_left_q - REP_W'(1);
                    busy_d     = 1'b1;
                    if (gap_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q - GAP_W'(1);
                    end else begin
                        // Back-to-back repetition with no idle cycle in between.
                        bit_idx_d     = first_idx_q;
                        x_d           = pattern_q[first_idx_q];
                        x_valid_d     = 1'b1;
                        frame_start_d = 1'b1;
                    end
                end else begin
                    state_d    = ST_IDLE;
                    rep_left_d = '0;
                    done_d     = 1'b1;
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    bit_idx_d = '0;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == '0) begin
                    state_d       = ST_SHIFT;
                    bit_idx_d     = first_idx_q;
                    x_d           = pattern_q[first_idx_q];
                    x_valid_d     = 1'b1;
                    frame_start_d = 1'b1;
                    busy_d        = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    busy_d    = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign x           = x_q;
    assign x_valid     = x_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial bit-stream generator that drives the single-bit input `x` of the Moore/Mealy sequence detectors. It is the transmit end of that serial link.
- Loads a pattern word and emits it MSB-first, one bit per clock.
- Optionally repeats the pattern with idle gaps between repetitions.
- Replaces hand-written stimulus timing and gives a synthesizable source for on-board detector demos.

Parameters:
- DATA_W, 8: pattern register width.
- LEN_W, 4: width of the length field; must satisfy 2^LEN_W > DATA_W.
- REP_W, 4: width of the repetition count.
- GAP_W, 4: width of the inter-repetition idle-cycle count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request transmission; sampled only when busy=0.
- pattern  in  DATA_W  bits to send; pattern[len-1] goes first, pattern[0] last.
- len  in  LEN_W  number of bits per repetition.
- reps  in  REP_W  number of repetitions.
- gap  in  GAP_W  idle cycles between repetitions.
- abort  in  1  terminate the current transmission.
- x  out  1  serial data to the detector.
- x_valid  out  1  x carries a pattern bit this cycle.
- frame_start  out  1  first bit of each repetition.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: one clk + one synchronous, active-high reset (`clk`, `rst`). On rst=1 at a rising edge: FSM=IDLE; x, x_valid, frame_start, busy, done all 0; internal counters 0. rst has priority over every other input.
- All outputs are registered.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - start=1 and len!=0 at edge E: capture pattern, len, reps, gap. Next state SHIFT.
  - From E: x=pattern[len-1], x_valid=1, frame_start=1, busy=1. Latency is 1 edge.
  - start=1 with len=0: no bits sent. done=1 for one cycle after E; state stays IDLE.
- Operand rules:
  - len > DATA_W is clamped to DATA_W.
  - reps=0 is treated as 1.
- SHIFT:
  - One bit per cycle, descending index.
  - frame_start=1 only on the first bit of each repetition.
  - After the last bit (index 0), if repetitions remain:
    - gap>0: go to GAP with x=0, x_valid=0.
    - gap=0: the next repetition's first bit follows immediately, with frame_start=1.
  - After the last bit of the last repetition: go to IDLE; done=1 and busy=0 for that one cycle; x=0, x_valid=0.
- GAP:
  - Hold x=0, x_valid=0, busy=1 for exactly `gap` cycles.
  - Then SHIFT, starting at pattern[len-1] with frame_start=1.
- Operand stability: captured operands are frozen for the whole transmission. Input changes while busy=1 have no effect.
- start while busy=1 is ignored; it is not queued.
- start in the done cycle (busy=0) is accepted; back-to-back transmissions are allowed.
- abort=1 at an edge while busy=1: next state IDLE; x, x_valid, frame_start, busy all 0; done is not pulsed.
  - abort with busy=0 has no effect.
  - abort together with start in IDLE: abort wins, start is dropped.
- When x_valid=0, x is always 0.
- A mid-transmission reset behaves as abort, without a done pulse.

Test Plan:
- Basic send: pattern=8'h0D, len=4, reps=1, gap=0, start pulsed before edge E.
  - Edges E..E+3: x=1,1,0,1, x_valid=1; frame_start only at E.
  - Edge E+4: done=1, busy=0, x_valid=0.
- Repeat with gap: pattern=8'h05, len=3, reps=2, gap=2.
  - x_valid=1,1,1,0,0,1,1,1 and x=1,0,1,0,0,1,0,1 over edges E..E+7.
  - frame_start at E and E+5; done at E+8.
- Zero gap repeat: pattern=8'h02, len=2, reps=3, gap=0.
  - x=1,0,1,0,1,0 contiguous with x_valid=1 throughout; frame_start at E, E+2, E+4; done at E+6.
- Boundaries:
  - len=0: done=1 at E, x_valid never asserts.
  - len=12 with pattern=8'hA5: 8 bits 1,0,1,0,0,1,0,1 are sent.
  - reps=0: one repetition.
- Abort/reset mid-stream:
  - abort at the third bit of an 8-bit send: outputs 0 the next cycle, no done pulse, busy=0.
  - rst mid-GAP: all outputs 0, and a new start is accepted the following edge.
- Ignored start:
  - start with a new pattern while busy: the original stream is unchanged.
  - start held high through the done cycle: a second transmission begins immediately, frame_start=1.
